// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a one-entry skid buffer.
// Holds {pc, instr} for decode and splits the held instruction into its fields.
module fetch_decode_reg #(
    parameter int unsigned PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] pc_in,
    input  logic [31:0]     instr_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] pc_out,
    output logic [31:0]     instr_out,
    output logic [4:0]      opcode,
    output logic [3:0]      rd,
    output logic [3:0]      rs1,
    output logic [3:0]      rs2,
    output logic [26:0]     imm_raw,
    output logic [1:0]      ext_sel
);

    logic            m_valid;
    logic [PC_W-1:0] m_pc;
    logic [31:0]     m_instr;
    logic            s_valid;
    logic [PC_W-1:0] s_pc;
    logic [31:0]     s_instr;

    logic accept;
    logic drain;

    assign accept = in_valid & in_ready;
    assign drain  = m_valid & out_ready;

    // Main (output) entry: refills from skid first so ordering is preserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_instr <= NOP_INSTR;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_instr <= NOP_INSTR;
        end else if (!m_valid || drain) begin
            if (s_valid) begin
                m_valid <= 1'b1;
                m_pc    <= s_pc;
                m_instr <= s_instr;
            end else if (accept) begin
                m_valid <= 1'b1;
                m_pc    <= pc_in;
                m_instr <= instr_in;
            end else begin
                m_valid <= 1'b0;
                m_pc    <= '0;
                m_instr <= NOP_INSTR;
            end
        end
    end

    // Skid entry: catches an accepted word whenever the main entry cannot take it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_pc    <= '0;
            s_instr <= NOP_INSTR;
        end else if (flush) begin
            s_valid <= 1'b0;
        end else if (!m_valid || drain) begin
            if (s_valid && accept) begin
                s_pc    <= pc_in;
                s_instr <= instr_in;
            end else if (s_valid) begin
                s_valid <= 1'b0;
            end
        end else if (accept) begin
            s_valid <= 1'b1;
            s_pc    <= pc_in;
            s_instr <= instr_in;
        end
    end

    assign in_ready  = !s_valid;
    assign out_valid = m_valid;
    assign pc_out    = m_pc;
    assign instr_out = m_instr;

    assign opcode  = instr_out[31:27];
    assign imm_raw = instr_out[26:0];
    assign ext_sel = instr_out[31:30];
    assign rd      = instr_out[11:8];
    assign rs1     = instr_out[7:4];
    assign rs2     = instr_out[3:0];

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed bench for fetch_decode_reg: reset, decode, backpressure, flush, skid refill, async reset.
module tb_fetch_decode_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [4:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [26:0] imm_raw;
    logic [1:0]  ext_sel;

    int errors = 0;
    int checks = 0;

    fetch_decode_reg #(.PC_W(32), .NOP_INSTR(32'h0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instr_in(instr_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .instr_out(instr_out),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm_raw(imm_raw), .ext_sel(ext_sel)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid = v;
        pc_in    = pc;
        instr_in = ins;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instr_out); end
        checks++; if (ext_sel !== 2'b00) begin errors++; $display("FAIL reset_ext_sel got=%b exp=00", ext_sel); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        drive(1'b1, 32'h100, 32'h4ABCD123);
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid got=%b exp=1", out_valid); end
        checks++; if (opcode !== 5'h09) begin errors++; $display("FAIL stream_opcode got=%h exp=09", opcode); end
        checks++; if (ext_sel !== 2'b01) begin errors++; $display("FAIL stream_ext_sel got=%b exp=01", ext_sel); end
        checks++; if (imm_raw !== 27'h2BCD123) begin errors++; $display("FAIL stream_imm got=%h exp=2bcd123", imm_raw); end
        checks++; if ({rd, rs1, rs2} !== 12'h123) begin errors++; $display("FAIL stream_regs got=%h exp=123", {rd, rs1, rs2}); end
        checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL stream_pc got=%h exp=100", pc_out); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty got=%b exp=0", out_valid); end
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL stream_nop got=%h exp=0", instr_out); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 32'hF000_0000 + 32'(i));
            step();
            checks++;
            if (out_valid !== 1'b1 || pc_out !== 32'h200 + 32'(i * 4) || instr_out !== 32'hF000_0000 + 32'(i)) begin
                errors++; $display("FAIL b2b_%0d got v=%b pc=%h ins=%h exp v=1 pc=%h", i, out_valid, pc_out, instr_out, 32'h200 + 32'(i * 4));
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, in_ready); end
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 32'hA000_0001);
        step();
        drive(1'b1, 32'h304, 32'hB000_0002);
        step();
        checks++; if (pc_out !== 32'h300 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid got pc=%h rdy=%b exp pc=300 rdy=0", pc_out, in_ready); end
        drive(1'b1, 32'h308, 32'hC000_0003);
        step();
        checks++; if (pc_out !== 32'h300 || instr_out !== 32'hA000_0001 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold got pc=%h ins=%h rdy=%b exp pc=300 ins=a0000001 rdy=0", pc_out, instr_out, in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (pc_out !== 32'h304 || instr_out !== 32'hB000_0002 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_b got pc=%h ins=%h rdy=%b exp pc=304 ins=b0000002 rdy=1", pc_out, instr_out, in_ready); end
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (pc_out !== 32'h308 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_c got pc=%h v=%b exp pc=308 v=1", pc_out, out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h400, 32'h1111_1111);
        step();
        drive(1'b1, 32'h404, 32'h2222_2222);
        step();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_full got rdy=%b v=%b exp rdy=0 v=1", in_ready, out_valid); end
        flush = 1'b1;
        drive(1'b1, 32'h408, 32'h3333_3333);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_out !== 32'h0) begin
            errors++; $display("FAIL flush_clear got v=%b rdy=%b ins=%h exp v=0 rdy=1 ins=0", out_valid, in_ready, instr_out); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_lost got=%b exp=0", out_valid); end
    endtask

    task automatic test_drain_accept();
        out_ready = 1'b0;
        drive(1'b1, 32'h500, 32'h5000_0000);
        step();
        drive(1'b1, 32'h504, 32'h5000_0004);
        step();
        out_ready = 1'b1;
        drive(1'b1, 32'h508, 32'h5000_0008);
        step();
        checks++; if (pc_out !== 32'h504 || instr_out !== 32'h5000_0004 || in_ready !== 1'b1) begin
            errors++; $display("FAIL da_refill got pc=%h ins=%h rdy=%b exp pc=504 rdy=1", pc_out, instr_out, in_ready); end
        out_ready = 1'b0;
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (pc_out !== 32'h504 || in_ready !== 1'b0) begin errors++; $display("FAIL da_skid got pc=%h rdy=%b exp pc=504 rdy=0", pc_out, in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (pc_out !== 32'h508 || instr_out !== 32'h5000_0008) begin errors++; $display("FAIL da_last got pc=%h ins=%h exp pc=508", pc_out, instr_out); end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h600, 32'h6000_0000);
        step();
        drive(1'b1, 32'h604, 32'h6000_0004);
        step();
        drive(1'b0, 32'h0, 32'h0);
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || pc_out !== 32'h0 || instr_out !== 32'h0) begin
            errors++; $display("FAIL async_rst got v=%b rdy=%b pc=%h ins=%h exp 0 1 0 0", out_valid, in_ready, pc_out, instr_out); end
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_after got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_drain_accept();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
